c5_bus_scheduler: RTL and testbench

C5_BUS_SCHEDULER -- requirements
Module: c5_bus_scheduler

---
 rtl/c5_bus_scheduler_pkg.sv | 26 ++
 rtl/c5_bus_scheduler_rr_pick.sv | 42 ++++
 rtl/c5_bus_scheduler.sv | 149 ++++++++++++++
 tb/tb_c5_bus_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/c5_bus_scheduler_pkg.sv
// Shared constants for the C5 bus scheduler.
//   - FSM state encodings (IDLE, ISSUE, RESP, GAP)
//   - requester index constants
//   - wait-counter width and an index-width helper
package c5_parameters;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    localparam int unsigned ReqCpuData  = 0;
    localparam int unsigned ReqCpuInstr = 1;
    localparam int unsigned ReqDisplay  = 2;
    localparam int unsigned ReqAudio    = 3;
    localparam int unsigned ReqSdcard   = 4;
    localparam int unsigned ReqUsb      = 5;

    // Wide enough for TIMEOUT up to 255.
    localparam int unsigned CntW = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/c5_bus_scheduler_rr_pick.sv
// Round-robin picker (combinational).
//   req_i    : request vector
//   last_i   : index of the previous winner
//   found_o  : some request is present
//   pick_o   : one-hot winner
//   idx_o    : binary winner index
// Search starts at last_i+1 and wraps at NREQ, so the previous winner is
// considered last.
module c5_rr_pick
    import c5_parameters::*;
#(
    parameter int unsigned NREQ = 6,
    parameter int unsigned IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic            found_o,
    output logic [NREQ-1:0] pick_o,
    output logic [IW-1:0]   idx_o
);

    int unsigned   cand;
    logic [IW-1:0] cidx;

    always_comb begin
        found_o = 1'b0;
        pick_o  = '0;
        idx_o   = '0;
        cand    = 0;
        cidx    = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(last_i) + off) % NREQ;
            cidx = cand[IW-1:0];
            if (!found_o && req_i[cidx]) begin
                found_o = 1'b1;
                idx_o   = cidx;
                pick_o  = NREQ'(1) << cidx;
            end
        end
    end

endmodule

// File: rtl/c5_bus_scheduler.sv
// C5 bus scheduler: round-robin arbitration of NREQ requesters onto one
// shared memory port, one transaction at a time.
//   I_clk, I_rst_n          : clock, synchronous active-low reset
//   I_stall                 : blocks new grants (in-flight work completes)
//   I_req/I_addr/I_we/I_wdata : per-requester command, flattened slices
//   O_ack/O_err/O_rdata     : one-cycle completion / timeout pulse, read data
//   O_grant                 : one-hot owner of the in-flight transaction
//   O_mem_*/I_mem_*         : shared memory command and completion
module c5_bus_scheduler
    import c5_parameters::*;
#(
    parameter int unsigned NREQ    = 6,
    parameter int unsigned AW      = 24,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_stall,
    input  logic [NREQ-1:0]    I_req,
    input  logic [NREQ*AW-1:0] I_addr,
    input  logic [NREQ-1:0]    I_we,
    input  logic [NREQ*DW-1:0] I_wdata,
    output logic [NREQ-1:0]    O_ack,
    output logic [NREQ-1:0]    O_err,
    output logic [DW-1:0]      O_rdata,
    output logic [NREQ-1:0]    O_grant,
    output logic             O_mem_valid,
    output logic             O_mem_we,
    output logic [AW-1:0]      O_mem_addr,
    output logic [DW-1:0]      O_mem_wdata,
    input  logic             I_mem_ready,
    input  logic [DW-1:0]      I_mem_rdata
);

    localparam int unsigned IW = idx_width(NREQ);

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            pick_found;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;

    c5_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i   (I_req),
        .last_i  (last_q),
        .found_o (pick_found),
        .pick_o  (pick_onehot),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (!I_stall && pick_found) begin
                    grant_d = pick_onehot;
                    last_d  = pick_idx;
                    addr_d  = I_addr[pick_idx*AW +: AW];
                    we_d    = I_we[pick_idx];
                    wdata_d = I_wdata[pick_idx*DW +: DW];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Ready wins even in the cycle the counter would hit TIMEOUT.
                if (I_mem_ready) begin
                    rdata_d = I_mem_rdata;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    cnt_d   = cnt_q + 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StGap;
            end
            StGap: begin
                // Extra idle cycle lets a completed requester drop I_req
                // before the next arbitration.
                grant_d = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q <= StIdle;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign O_mem_valid = (state_q == StIssue);
    assign O_mem_we    = we_q;
    assign O_mem_addr  = addr_q;
    assign O_mem_wdata = wdata_q;
    assign O_grant     = grant_q;
    assign O_rdata     = rdata_q;
    assign O_ack       = (state_q == StResp && !err_q) ? grant_q : '0;
    assign O_err       = (state_q == StResp && err_q) ? grant_q : '0;

endmodule

// File: tb/tb_c5_bus_scheduler.sv
// Directed bench for c5_bus_scheduler (default parameters).
module tb_c5_bus_scheduler;

    localparam int unsigned NREQ = 6;
    localparam int unsigned AW   = 24;
    localparam int unsigned DW   = 32;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ-1:0]    we;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    err;
    logic [DW-1:0]      rdata;
    logic [NREQ-1:0]    grant;
    logic              mem_valid;
    logic              mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic              mem_ready;
    logic [DW-1:0]      mem_rdata;

    int nchk = 0;
    int nerr = 0;

    c5_bus_scheduler dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_stall     (stall),
        .I_req       (req),
        .I_addr      (addr),
        .I_we        (we),
        .I_wdata     (wdata),
        .O_ack       (ack),
        .O_err       (err),
        .O_rdata     (rdata),
        .O_grant     (grant),
        .O_mem_valid (mem_valid),
        .O_mem_we    (mem_we),
        .O_mem_addr  (mem_addr),
        .O_mem_wdata (mem_wdata),
        .I_mem_ready (mem_ready),
        .I_mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        int          n;
        logic        rst_n;
        logic        stall;
        logic [5:0]  req;
        logic        rdy;
        logic [31:0] mrd;
        logic        ev;
        logic [5:0]  eg;
        logic [5:0]  ea;
        logic [5:0]  ee;
        logic [31:0] erd;
        logic [23:0] eaddr;
        logic        ewe;
        logic [31:0] ewd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name, input int n, input logic r, input logic s,
                                input logic [5:0] rq, input logic rdy, input logic [31:0] mrd,
                                input logic ev, input logic [5:0] eg, input logic [5:0] ea,
                                input logic [5:0] ee, input logic [31:0] erd,
                                input logic [23:0] eaddr, input logic ewe,
                                input logic [31:0] ewd);
        vec_t v;
        v.name = name; v.n = n; v.rst_n = r; v.stall = s; v.req = rq; v.rdy = rdy;
        v.mrd = mrd; v.ev = ev; v.eg = eg; v.ea = ea; v.ee = ee; v.erd = erd;
        v.eaddr = eaddr; v.ewe = ewe; v.ewd = ewd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            rst_n     = v.rst_n;
            stall     = v.stall;
            req       = v.req;
            mem_ready = v.rdy;
            mem_rdata = v.mrd;
            step();
            check({v.name, ".valid"}, 32'(mem_valid), 32'(v.ev));
            check({v.name, ".grant"}, 32'(grant), 32'(v.eg));
            check({v.name, ".ack"}, 32'(ack), 32'(v.ea));
            check({v.name, ".err"}, 32'(err), 32'(v.ee));
            if (v.ea != 0 || v.ee != 0 || !v.rst_n)
                check({v.name, ".rdata"}, rdata, v.erd);
            if (v.ev || !v.rst_n) begin
                check({v.name, ".addr"}, 32'(mem_addr), 32'(v.eaddr));
                check({v.name, ".we"}, 32'(mem_we), 32'(v.ewe));
                check({v.name, ".wdata"}, mem_wdata, v.ewd);
            end
        end
    endtask

    int        got;
    int        vcnt;
    logic [5:0] rr_g[7];
    int        rr_c[7];

    initial begin
        rst_n = 1'b0; stall = 1'b0; req = '0; mem_ready = 1'b0; mem_rdata = '0;
        we = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            addr[i*AW +: AW]  = 24'h000100 + 24'(i * 16);
            wdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end

        //              name       n  rst st req        rdy mrd            ev eg         ea         ee  erd            eaddr       we wdata
        tbl.push_back(mk("reset",   1, 0, 0, 6'b000000, 0, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("grant0",  1, 1, 0, 6'b000001, 0, 32'h0,          1, 6'b000001, 6'b000000, 0, 32'h0,          24'h000100, 0, 32'hA0000000));
        tbl.push_back(mk("wait0",   2, 1, 0, 6'b000001, 0, 32'h0,          1, 6'b000001, 6'b000000, 0, 32'h0,          24'h000100, 0, 32'hA0000000));
        tbl.push_back(mk("ack0",    1, 1, 0, 6'b000001, 1, 32'hDEADBEEF,   0, 6'b000001, 6'b000001, 0, 32'hDEADBEEF,   24'h0,      0, 32'h0));
        tbl.push_back(mk("gap0",    1, 1, 0, 6'b000000, 1, 32'h0,          0, 6'b000001, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("idle0",   2, 1, 0, 6'b000000, 1, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("stall",  10, 1, 1, 6'b000110, 0, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("unstall", 1, 1, 0, 6'b000110, 0, 32'h0,          1, 6'b000010, 6'b000000, 0, 32'h0,          24'h000110, 1, 32'hA0000001));
        tbl.push_back(mk("ack1",    1, 1, 1, 6'b000110, 1, 32'h12345678,   0, 6'b000010, 6'b000010, 0, 32'h12345678,   24'h0,      0, 32'h0));
        tbl.push_back(mk("gap1",    1, 1, 1, 6'b000100, 0, 32'h0,          0, 6'b000010, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("idle2",   1, 1, 0, 6'b000100, 0, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("grant2",  1, 1, 0, 6'b000100, 0, 32'h0,          1, 6'b000100, 6'b000000, 0, 32'h0,          24'h000120, 0, 32'hA0000002));
        tbl.push_back(mk("rstmid",  1, 0, 0, 6'b000100, 1, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("regrant2",1, 1, 0, 6'b000100, 0, 32'h0,          1, 6'b000100, 6'b000000, 0, 32'h0,          24'h000120, 0, 32'hA0000002));
        tbl.push_back(mk("ack2",    1, 1, 0, 6'b000100, 1, 32'hCAFEF00D,   0, 6'b000100, 6'b000100, 0, 32'hCAFEF00D,   24'h0,      0, 32'h0));
        tbl.push_back(mk("gap2",    1, 1, 0, 6'b000000, 0, 32'h0,          0, 6'b000100, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));
        tbl.push_back(mk("idle3",   1, 1, 0, 6'b000000, 0, 32'h0,          0, 6'b000000, 6'b000000, 0, 32'h0,          24'h0,      0, 32'h0));

        foreach (tbl[i]) run_row(tbl[i]);

        // Round-robin with all requesting and memory always ready.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req = 6'b111111; mem_ready = 1'b1; mem_rdata = 32'h55AA55AA;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (mem_valid && got < 7) begin
                rr_g[got] = grant;
                rr_c[got] = c;
                got++;
            end
        end
        check("rr_count", 32'(got), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < got) begin
                check($sformatf("rr_grant%0d", k), 32'(rr_g[k]), 32'(6'b000001 << (k % 6)));
                if (k > 0)
                    check($sformatf("rr_spacing%0d", k), 32'(rr_c[k] - rr_c[k-1]), 32'd4);
            end
        end

        // Drain to idle without reset so O_rdata holds nonzero data.
        req = '0;
        for (int c = 0; c < 4; c++) step();
        check("drain_ack_data", rdata, 32'h55AA55AA);

        // Timeout for requester 3.
        mem_ready = 1'b0;
        req = 6'b001000;
        step();
        check("to_valid", 32'(mem_valid), 32'd1);
        check("to_grant", 32'(grant), 32'(6'b001000));
        vcnt = 1;
        for (int c = 0; c < 300; c++) begin
            step();
            if (!mem_valid) break;
            vcnt++;
        end
        check("to_len", 32'(vcnt), 32'd255);
        check("to_err", 32'(err), 32'(6'b001000));
        check("to_ack", 32'(ack), 32'd0);
        check("to_rdata", rdata, 32'd0);
        step();
        check("to_err_once", 32'(err), 32'd0);
        check("to_ack_after", 32'(ack), 32'd0);
        req = '0;
        step(); step();

        // Requester 4 drops its request mid-transaction; still acked.
        req = 6'b010000;
        step();
        check("drop_grant", 32'(grant), 32'(6'b010000));
        req = '0;
        step(); step();
        check("drop_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        check("drop_ack", 32'(ack), 32'(6'b010000));
        check("drop_err", 32'(err), 32'd0);
        check("drop_rdata", rdata, 32'h0BADF00D);
        mem_ready = 1'b0;
        step(); step(); step();

        // Ready arrives in the last allowed wait cycle: ack wins.
        req = 6'b010000;
        step();
        for (int c = 0; c < 254; c++) step();
        check("edge_valid", 32'(mem_valid), 32'd1);
        check("edge_no_err", 32'(err), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h600DCAFE;
        step();
        check("edge_ack", 32'(ack), 32'(6'b010000));
        check("edge_err", 32'(err), 32'd0);
        check("edge_rdata", rdata, 32'h600DCAFE);
        mem_ready = 1'b0; req = '0;
        step(); step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
